row_buf_writer: RTL and testbench

- Write-side companion to the row-buffer read controller.
- Accepts a pixel stream over a valid/ready handshake and pushes it into the row-buffer FIFO with a registered write strobe.
- Tracks FIFO occupancy (writes minus reader pops), stops accepting at one full window batch (ROW*COL entries), and reports occupancy and window position to the reader side.

---
 rtl/row_buf_writer_pkg.sv | 22 ++
 rtl/row_buf_writer_if.sv | 19 +
 rtl/row_buf_occ_cnt.sv | 48 ++++
 rtl/row_buf_writer.sv | 131 +++++++++++++
 tb/tb_row_buf_writer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/row_buf_writer_pkg.sv
// Shared types and helpers for the row-buffer writer.
// Contents:
//   state_t     - writer FSM state (IDLE/FILL/WAIT), 2-bit encoding
//   calc_limit  - number of entries in one full window batch (ROW*COL)
//   idx_width   - width of a position index counting 0..n-1, at least 1 bit
package row_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    WAIT = 2'd2
  } state_t;

  function automatic int calc_limit(input int rows, input int cols);
    return rows * cols;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/row_buf_writer_if.sv
// Pixel stream into the row-buffer writer.
// Signals:
//   i_data  - pixel, driven by the source
//   i_valid - source has a pixel on i_data
//   o_ready - writer accepts this cycle
// Handshake: a pixel moves when i_valid && o_ready are both high at a rising
// clock edge. While i_valid is high and o_ready is low the source holds i_data
// stable. o_ready may change regardless of i_valid.
// Modports: master = pixel source, slave = writer.
interface row_buf_writer_if #(
  parameter int W_DATA = 8
);
  logic [W_DATA-1:0] i_data;
  logic              i_valid;
  logic              o_ready;

  modport master (output i_data, output i_valid, input o_ready);
  modport slave  (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/row_buf_occ_cnt.sv
// Up/down saturating occupancy counter.
// Ports:
//   clk, rst  - clock, async active-high reset
//   inc       - one entry added this cycle
//   dec       - one entry removed this cycle (ignored when count is 0)
//   count     - registered occupancy
//   count_nxt - occupancy after the coming edge
//   eq_limit  - registered flag, high while count == LIMIT
module row_buf_occ_cnt #(
  parameter int W     = 9,
  parameter int LIMIT = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic [W-1:0] count_nxt,
  output logic         eq_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic dec_eff;

  // A pop from an empty count is meaningless and is dropped.
  assign dec_eff = dec && (count != '0);

  always_comb begin
    count_nxt = count;
    if (inc && !dec_eff) begin
      if (count < LIM) count_nxt = count + 1'b1;
    end else if (dec_eff && !inc) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      eq_limit <= 1'b0;
    end else begin
      count    <= count_nxt;
      eq_limit <= (count_nxt == LIM);
    end
  end

endmodule

// File: rtl/row_buf_writer.sv
// Row-buffer writer: takes a pixel stream and pushes it into the row-buffer
// FIFO one cycle after each accept, tracks FIFO occupancy against reader pops,
// stops accepting at one full window batch (ROW*COL) and reports occupancy and
// window position of the last accepted pixel.
// Ports:
//   i_clk, i_rst        - clock, async active-high reset
//   i_enable            - level, permits filling
//   pix                 - pixel stream (slave modport)
//   i_fifo_full         - FIFO full, gates o_ready only
//   i_fifo_rd_en        - reader pop strobe
//   o_fifo_wr_en/_data  - registered FIFO write
//   o_occupants         - tracked occupancy
//   o_batch_ready       - occupancy equals ROW*COL
//   o_col_idx/o_row_idx - position of the last accepted pixel
//   o_last              - pulse with the write of element (ROW-1, COL-1)
//   o_err               - sticky error, only with ROW_BUF_WR_ERR_EN defined
//   o_state             - FSM state for observation
// Macro ROW_BUF_WR_ERR_EN enables the underflow / occupancy-mismatch error.
module row_buf_writer
  import row_buf_pkg::*;
#(
  parameter int COL    = 3,
  parameter int ROW    = 9,
  parameter int W_ADDR = 8,
  parameter int W_DATA = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  row_buf_writer_if.slave           pix,
  input  logic                      i_fifo_full,
  input  logic                      i_fifo_rd_en,
  output logic                      o_fifo_wr_en,
  output logic [W_DATA-1:0]         o_fifo_wr_data,
  output logic [W_ADDR:0]           o_occupants,
  output logic                      o_batch_ready,
  output logic [idx_width(COL)-1:0] o_col_idx,
  output logic [idx_width(ROW)-1:0] o_row_idx,
  output logic                      o_last,
  output logic                      o_err,
  output state_t                    o_state
);

  localparam int WC    = idx_width(COL);
  localparam int WR    = idx_width(ROW);
  localparam int LIMIT = calc_limit(ROW, COL);

  localparam logic [W_ADDR:0] LIM      = (W_ADDR + 1)'(LIMIT);
  localparam logic [WC-1:0]   COL_LAST = WC'(COL - 1);
  localparam logic [WR-1:0]   ROW_LAST = WR'(ROW - 1);

  state_t          state;
  logic            accept;
  logic [W_ADDR:0] occ_nxt;
  // Position the next accepted pixel will take.
  logic [WC-1:0]   pos_col;
  logic [WR-1:0]   pos_row;

  assign pix.o_ready = (state == FILL) && !i_fifo_full && (o_occupants < LIM);
  assign accept      = pix.i_valid && pix.o_ready;
  assign o_state     = state;

  row_buf_occ_cnt #(
    .W     (W_ADDR + 1),
    .LIMIT (LIMIT)
  ) u_occ (
    .clk       (i_clk),
    .rst       (i_rst),
    .inc       (accept),
    .dec       (i_fifo_rd_en),
    .count     (o_occupants),
    .count_nxt (occ_nxt),
    .eq_limit  (o_batch_ready)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= IDLE;
      o_fifo_wr_en   <= 1'b0;
      o_fifo_wr_data <= '0;
      o_col_idx      <= '0;
      o_row_idx      <= '0;
      o_last         <= 1'b0;
      pos_col        <= '0;
      pos_row        <= '0;
    end else begin
      o_fifo_wr_en <= accept;
      o_last       <= accept && (pos_col == COL_LAST) && (pos_row == ROW_LAST);

      if (accept) begin
        o_fifo_wr_data <= pix.i_data;
        o_col_idx      <= pos_col;
        o_row_idx      <= pos_row;
        if (pos_col == COL_LAST) begin
          pos_col <= '0;
          pos_row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
        end else begin
          pos_col <= pos_col + 1'b1;
        end
      end

      // Transitions look at the post-update occupancy so the batch boundary
      // and the first pop are seen on the same edge that changes the count.
      case (state)
        IDLE: if (i_enable) state <= FILL;
        FILL: begin
          if (occ_nxt == LIM) state <= WAIT;
          else if (!i_enable) state <= IDLE;
        end
        WAIT: if (occ_nxt < LIM) state <= i_enable ? FILL : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROW_BUF_WR_ERR_EN
  // Underflow: a pop with nothing tracked. Mismatch: the FIFO claims full
  // while we believe at least two slots are still free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if ((i_fifo_rd_en && (o_occupants == '0)) ||
                 (i_fifo_full && (o_occupants < LIM - 1'b1))) begin
      o_err <= 1'b1;
    end
  end
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_row_buf_writer.sv
module tb_row_buf_writer;
  import row_buf_pkg::*;

  logic       clk;
  logic       rst;
  logic       i_enable;
  logic       i_fifo_full;
  logic       i_fifo_rd_en;
  logic       o_fifo_wr_en;
  logic [7:0] o_fifo_wr_data;
  logic [8:0] o_occupants;
  logic       o_batch_ready;
  logic [1:0] o_col_idx;
  logic [3:0] o_row_idx;
  logic       o_last;
  logic       o_err;
  state_t     o_state;

  row_buf_writer_if #(.W_DATA(8)) pix ();

  row_buf_writer #(
    .COL(3), .ROW(9), .W_ADDR(8), .W_DATA(8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_enable       (i_enable),
    .pix            (pix),
    .i_fifo_full    (i_fifo_full),
    .i_fifo_rd_en   (i_fifo_rd_en),
    .o_fifo_wr_en   (o_fifo_wr_en),
    .o_fifo_wr_data (o_fifo_wr_data),
    .o_occupants    (o_occupants),
    .o_batch_ready  (o_batch_ready),
    .o_col_idx      (o_col_idx),
    .o_row_idx      (o_row_idx),
    .o_last         (o_last),
    .o_err          (o_err),
    .o_state        (o_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state: {last_flag, data}
  logic [8:0] exp_q[$];
  logic [8:0] exp_e;
  int         exp_pos;
  int         chk_cnt;
  int         err_cnt;
  int         wr_cnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor: writes come out one cycle after the accept they belong to.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_fifo_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", exp_q.size(), 1);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_data", o_fifo_wr_data, exp_e[7:0]);
          check("wr_last", o_last, exp_e[8]);
        end
      end else if (o_last) begin
        check("last_without_wr", o_last, 0);
      end
      if (pix.i_valid && pix.o_ready) begin
        exp_q.push_back({exp_pos == 26, pix.i_data});
        exp_pos = (exp_pos == 26) ? 0 : exp_pos + 1;
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_pos = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_pixel(input logic [7:0] d);
    int   n;
    logic done;
    n    = 0;
    done = 1'b0;
    pix.i_data  = d;
    pix.i_valid = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
      if (pix.o_ready) done = 1'b1;
    end
    if (!done) check("accept_timeout", done, 1);
    @(posedge clk);
    #1;
    pix.i_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"}, o_fifo_wr_en, 0);
    check({tag, "_wr_data"}, o_fifo_wr_data, 0);
    check({tag, "_occ"}, o_occupants, 0);
    check({tag, "_batch"}, o_batch_ready, 0);
    check({tag, "_col"}, o_col_idx, 0);
    check({tag, "_row"}, o_row_idx, 0);
    check({tag, "_last"}, o_last, 0);
    check({tag, "_err"}, o_err, 0);
    check({tag, "_ready"}, pix.o_ready, 0);
    check({tag, "_state"}, o_state, IDLE);
  endtask

  logic acc;
  logic occ_ok;
  int   w0;

  initial begin
    chk_cnt = 0;
    err_cnt = 0;
    wr_cnt  = 0;
    exp_pos = 0;
    rst          = 1'b1;
    i_enable     = 1'b0;
    i_fifo_full  = 1'b0;
    i_fifo_rd_en = 1'b0;
    pix.i_data   = '0;
    pix.i_valid  = 1'b0;
    #1;
    check_all_zero("reset");
    do_reset();

    // full batch of 27 pixels back to back
    i_enable = 1'b1;
    cycles(1);
    for (int k = 0; k < 27; k++) push_pixel(8'(k));
    @(negedge clk);
    check("t1_occ", o_occupants, 27);
    check("t1_batch", o_batch_ready, 1);
    check("t1_ready", pix.o_ready, 0);
    check("t1_state", o_state, WAIT);
    check("t1_col", o_col_idx, 2);
    check("t1_row", o_row_idx, 8);
    cycles(1);
    check("t1_wr_cnt", wr_cnt, 27);

    // pops for 8 cycles with the source always valid
    pix.i_data   = 8'h1B;
    pix.i_valid  = 1'b1;
    i_fifo_rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = pix.o_ready;
      if (i == 1) begin
        check("t2_ready_back", pix.o_ready, 1);
        check("t2_state_fill", o_state, FILL);
        check("t2_batch_drop", o_batch_ready, 0);
        check("t2_occ_first_pop", o_occupants, 26);
      end
      occ_ok = (o_occupants >= 26) && (o_occupants <= 27);
      check("t2_occ_range", occ_ok, 1);
      @(posedge clk);
      #1;
      if (acc) pix.i_data = pix.i_data + 8'd1;
    end
    i_fifo_rd_en = 1'b0;
    @(negedge clk);
    check("t2_ready_refill", pix.o_ready, 1);
    @(posedge clk);
    #1;
    pix.i_valid = 1'b0;
    @(negedge clk);
    check("t2_occ_end", o_occupants, 27);
    check("t2_batch_end", o_batch_ready, 1);
    check("t2_state_end", o_state, WAIT);
    check("t2_col", o_col_idx, 1);
    check("t2_row", o_row_idx, 2);

    // simultaneous accept and pop at occupancy 10
    do_reset();
    check("t3_rst_occ", o_occupants, 0);
    i_enable = 1'b1;
    cycles(1);
    for (int k = 0; k < 10; k++) push_pixel(8'h40 + 8'(k));
    @(negedge clk);
    check("t3_occ10", o_occupants, 10);
    @(posedge clk);
    #1;
    pix.i_data   = 8'h4A;
    pix.i_valid  = 1'b1;
    i_fifo_rd_en = 1'b1;
    @(negedge clk);
    check("t3_ready", pix.o_ready, 1);
    @(posedge clk);
    #1;
    pix.i_valid  = 1'b0;
    i_fifo_rd_en = 1'b0;
    @(negedge clk);
    check("t3_occ_same", o_occupants, 10);
    check("t3_wr_en", o_fifo_wr_en, 1);
    check("t3_col", o_col_idx, 1);
    check("t3_row", o_row_idx, 3);

    // FIFO full holds off a valid pixel for 5 cycles
    @(posedge clk);
    #1;
    i_fifo_full = 1'b1;
    pix.i_data  = 8'h55;
    pix.i_valid = 1'b1;
    w0 = wr_cnt;
    repeat (5) begin
      @(negedge clk);
      check("t4_ready_full", pix.o_ready, 0);
    end
    check("t4_col_frozen", o_col_idx, 1);
    check("t4_row_frozen", o_row_idx, 3);
    check("t4_state", o_state, FILL);
    @(posedge clk);
    #1;
    check("t4_no_wr", wr_cnt, w0);
    i_fifo_full = 1'b0;
    @(negedge clk);
    check("t4_ready_rel", pix.o_ready, 1);
    @(posedge clk);
    #1;
    pix.i_valid = 1'b0;
    @(negedge clk);
    check("t4_wr_en", o_fifo_wr_en, 1);
    cycles(2);
    check("t4_wr_once", wr_cnt, w0 + 1);
    check("t4_occ", o_occupants, 11);
    check("t4_col", o_col_idx, 2);
    check("t4_row", o_row_idx, 3);
`ifdef ROW_BUF_WR_ERR_EN
    check("t4_err_mismatch", o_err, 1);
`else
    check("t4_err_off", o_err, 0);
`endif
    i_enable = 1'b0;
    cycles(1);
    check("t4_state_idle", o_state, IDLE);
    check("t4_ready_idle", pix.o_ready, 0);
    check("t4_occ_hold", o_occupants, 11);
    check("t4_col_hold", o_col_idx, 2);

    // asynchronous reset mid-batch with a write pending
    do_reset();
    i_enable = 1'b1;
    cycles(1);
    for (int k = 0; k < 14; k++) push_pixel(8'h60 + 8'(k));
    check("t5_occ14", o_occupants, 14);
    check("t5_wr_pending", o_fifo_wr_en, 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    exp_pos = 0;
    #1;
    check_all_zero("t5_async");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    i_enable = 1'b0;
    w0 = wr_cnt;
    cycles(3);
    check("t5_no_wr", wr_cnt, w0);
    check("t5_state", o_state, IDLE);
    check("t5_occ", o_occupants, 0);

    // pop at occupancy 0
    do_reset();
    i_fifo_rd_en = 1'b1;
    cycles(1);
    i_fifo_rd_en = 1'b0;
    check("t6_occ_sat", o_occupants, 0);
`ifdef ROW_BUF_WR_ERR_EN
    check("t6_err_set", o_err, 1);
    cycles(3);
    check("t6_err_hold", o_err, 1);
`else
    check("t6_err_off", o_err, 0);
    cycles(3);
    check("t6_err_off_hold", o_err, 0);
`endif
    do_reset();
    check("t6_err_clr", o_err, 0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
